array_reducer: RTL and testbench
================================

# array_reducer

Parametrised memory-reduction engine, successor to the fixed ten-word summing loop in the single-cycle CPU top level. On `startin` it walks a programmable window of its local data memory, one word per clock, and combines the words with a selectable operator: sum, unsigned max, unsigned min or XOR. It writes the result back to memory and reports it on the `regNo`/`val` debug pair. It sits beside the CPU datapath as a memory-side accelerator with a start/busy/done handshake.

## Interface
- `DATA_W`, 32, word width.
- `DEPTH`, 16, number of memory words (≥2).
- `ADDR_W`, $clog2(DEPTH), address width.
- `RES_REG`, 5'd11, register number reported in `regNo` on completion.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `startin`  in  1  start request; sampled only in IDLE.
- `mode`  in  2  00 sum, 01 umax, 10 umin, 11 xor; latched at start.
- `base`  in  ADDR_W  first element address; latched at start.
- `len`  in  ADDR_W+1  element count, 0..DEPTH; latched at start; values >DEPTH clamp to DEPTH.
- `dst`  in  ADDR_W  write-back address; latched at start.
- `load_en`  in  1  memory preload write strobe.
- `load_addr`  in  ADDR_W  preload address.
- `load_data`  in  DATA_W  preload data.
- `busy`  out  1  high from the start edge until the write-back edge.
- `done`  out  1  one-cycle completion pulse.
- `val`  out  DATA_W  last result; held until the next completion.
- `regNo`  out  5  `RES_REG` after the first completion.
- `ovf`  out  1  sum mode only: an unsigned carry-out occurred during the last operation.

## Operation
- States: IDLE, ACC, WB.
- **IDLE**
  - `startin`=1 latches `mode`, `base`, `dst` and the clamped `len`.
  - Accumulator loads the identity value: sum/xor 0, umax 0, umin all-ones.
  - `idx` and the sticky overflow clear.
  - Next state is ACC if `len`≠0, else WB. `busy` goes high.
- **ACC**, each cycle:
  - Read address `(base+idx) mod DEPTH`; wraps past DEPTH-1 to 0.
  - acc ← op(acc, mem[addr]); `idx`++.
  - Sum is modulo 2^DATA_W. Carry-out sets the sticky overflow.
  - After the `len`-th element, go to WB.
- **WB**:
  - mem[dst] ← acc; `val` ← acc; `regNo` ← `RES_REG`; `ovf` ← sticky overflow.
  - `done` ← 1, `busy` ← 0, next state IDLE.
- `done` clears on the next edge unless another operation completes.
- **Preload**: `load_en` writes memory only while not busy. It is ignored during ACC/WB (no stall, no error).
- `startin` is ignored while busy. A start seen in the cycle `done` is high is accepted (back-to-back).
- **Overlap**: the window may include `dst`. Reads use the pre-write-back contents.
- **Reset** (any time, including mid-operation):
  - State IDLE; `busy`, `done`, `ovf` = 0; `val` = 0; `regNo` = 0; `idx`, acc = 0.
  - Memory contents are not reset. An interrupted operation performs no write-back.

## Timing
- `startin` sampled at edge T → `busy`=1 after T.
- Elements are consumed at edges T+1 … T+len. Write-back and `done`=1 occur at edge T+len+1.
- Latency from start to done is len+1 cycles; len=0 gives 1 cycle.
- `val`, `regNo` and `ovf` update on the same edge as `done` rises.
- Memory read is combinational (array read) within the ACC cycle. Write-back is synchronous.

## Structure
- Package `reducer_pkg`:
  - mode enum (`RED_SUM`, `RED_MAX`, `RED_MIN`, `RED_XOR`).
  - state enum (`ST_IDLE`, `ST_ACC`, `ST_WB`).
  - Function returning the identity value per mode.
- Sub-module `reduce_alu`: combinational; inputs acc, operand, mode; outputs result and carry.
- The top holds the memory, FSM, counters and output registers.

## Test plan
- Preload mem[0..9]=1..10, base=0, len=10, dst=10, sum → `done` 11 cycles after the start edge, `val`=55, `regNo`=11, mem[10]=55, `ovf`=0.
- Wrap-around, DEPTH=16: base=14, len=4, mem[14,15,0,1]=5,7,9,11, umax → `val`=11; then umin on the same window → `val`=5.
- Overflow: mem[0]=mem[1]=32'hFFFF_FFFF, len=2, sum → `val`=32'hFFFF_FFFE, `ovf`=1; a following XOR run clears `ovf`, `val`=0.
- Edge cases: len=0 with umin → `done` after 1 cycle, `val`=32'hFFFF_FFFF. len=31 → clamped to 16 elements.
- Pulse `startin` and `load_en` while busy → no restart, memory unchanged, result matches an unperturbed run.
- Assert `rst_n`=0 mid-ACC → `busy`/`done`/`val`/`regNo` go to 0 immediately, `dst` is not written, and a fresh start completes correctly.

Source files
------------

// File: rtl/reducer_pkg.sv
// Shared types for the array reducer: operator and FSM encodings plus per-operator identity.
// No logic of its own; no latency or backpressure.
package reducer_pkg;

    localparam int RED_MAX_W = 64;

    typedef enum logic [1:0] {
        RED_SUM = 2'b00,
        RED_MAX = 2'b01,
        RED_MIN = 2'b10,
        RED_XOR = 2'b11
    } red_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC  = 2'b01,
        ST_WB   = 2'b10
    } red_state_t;

    // Callers truncate to their own word width; only umin needs a non-zero seed.
    function automatic logic [RED_MAX_W-1:0] red_identity(input red_mode_t m);
        return (m == RED_MIN) ? {RED_MAX_W{1'b1}} : {RED_MAX_W{1'b0}};
    endfunction

endpackage

// File: rtl/reduce_alu.sv
// Combines the running accumulator with one memory word under the selected operator.
// Purely combinational, zero latency; no flow control.
module reduce_alu
    import reducer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    input  red_mode_t         mode,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum    = {1'b0, acc} + {1'b0, operand};
        result = sum[DATA_W-1:0];
        carry  = 1'b0;
        case (mode)
            RED_SUM: carry  = sum[DATA_W];
            RED_MAX: result = (operand > acc) ? operand : acc;
            RED_MIN: result = (operand < acc) ? operand : acc;
            RED_XOR: result = acc ^ operand;
            default: result = sum[DATA_W-1:0];
        endcase
    end

endmodule

// File: rtl/array_reducer.sv
// Memory-side reduction engine: folds a wrapping window of local memory into one word and writes it back.
// Latency len+1 cycles from start to done (len=0 gives 1); one element per cycle.
// No backpressure: starts and preloads arriving while busy are dropped silently.
module array_reducer
    import reducer_pkg::*;
#(
    parameter int         DATA_W  = 32,
    parameter int         DEPTH   = 16,
    parameter int         ADDR_W  = $clog2(DEPTH),
    parameter logic [4:0] RES_REG = 5'd11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              startin,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic [ADDR_W-1:0] dst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] val,
    output logic [4:0]        regNo,
    output logic              ovf
);

    localparam int              CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    red_state_t        state;
    red_state_t        state_nxt;
    red_mode_t         mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] dst_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  idx_q;
    logic [DATA_W-1:0] acc_q;
    logic              sticky_q;
    logic              done_q;
    logic [DATA_W-1:0] val_q;
    logic [4:0]        regno_q;
    logic              ovf_q;

    logic [CNT_W-1:0]  len_clamp;
    logic [CNT_W-1:0]  idx_inc;
    logic [CNT_W-1:0]  rd_sum;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;

    assign len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
    assign idx_inc   = idx_q + CNT_W'(1);

    // base and idx are both below DEPTH, so a single conditional subtract wraps the window.
    assign rd_sum  = {1'b0, base_q} + idx_q;
    assign rd_addr = ADDR_W'((rd_sum >= DEPTH_L) ? (rd_sum - DEPTH_L) : rd_sum);

    reduce_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .acc     (acc_q),
        .operand (mem[rd_addr]),
        .mode    (mode_q),
        .result  (alu_res),
        .carry   (alu_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (startin) begin
                    state_nxt = (len_clamp == '0) ? ST_WB : ST_ACC;
                end
            end
            ST_ACC: begin
                if (idx_inc == len_q) begin
                    state_nxt = ST_WB;
                end
            end
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= RED_SUM;
            base_q   <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            done_q   <= 1'b0;
            val_q    <= '0;
            regno_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (startin) begin
                        mode_q   <= red_mode_t'(mode);
                        base_q   <= base;
                        dst_q    <= dst;
                        len_q    <= len_clamp;
                        idx_q    <= '0;
                        acc_q    <= DATA_W'(red_identity(red_mode_t'(mode)));
                        sticky_q <= 1'b0;
                    end
                end
                ST_ACC: begin
                    acc_q <= alu_res;
                    idx_q <= idx_inc;
                    if (alu_carry) begin
                        sticky_q <= 1'b1;
                    end
                end
                ST_WB: begin
                    val_q   <= acc_q;
                    regno_q <= RES_REG;
                    ovf_q   <= sticky_q;
                    done_q  <= 1'b1;
                end
                default: begin
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Memory is deliberately not reset; an aborted run leaves state IDLE so no write-back fires.
    always_ff @(posedge clk) begin
        if (state == ST_WB) begin
            mem[dst_q] <= acc_q;
        end else if (load_en && !busy) begin
            mem[load_addr] <= load_data;
        end
    end

    assign busy  = (state != ST_IDLE);
    assign done  = done_q;
    assign val   = val_q;
    assign regNo = regno_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_array_reducer.sv
// Directed bench for array_reducer with a transaction-level reference model and per-cycle output compare.
module tb_array_reducer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        startin = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [3:0]  base = '0;
    logic [4:0]  len = '0;
    logic [3:0]  dst = '0;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic        busy;
    logic        done;
    logic [31:0] val;
    logic [4:0]  regNo;
    logic        ovf;

    int tests = 0;
    int fails = 0;
    bit checking = 0;

    array_reducer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .startin   (startin),
        .mode      (mode),
        .base      (base),
        .len       (len),
        .dst       (dst),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .busy      (busy),
        .done      (done),
        .val       (val),
        .regNo     (regNo),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole result computed at the start edge, then revealed after len+1 edges.
    logic [31:0] model_mem [16];
    bit          m_busy = 0;
    bit          m_done = 0;
    logic [31:0] m_val = '0;
    logic [4:0]  m_regno = '0;
    bit          m_ovf = 0;
    int          m_cnt = 0;
    logic [31:0] m_res = '0;
    bit          m_res_ovf = 0;
    int          m_dst = 0;

    task automatic reduce(input int md, input int b, input int l, output logic [31:0] r, output bit o);
        int n;
        logic [32:0] s;
        logic [31:0] w;
        n = (l > 16) ? 16 : l;
        r = (md == 2) ? 32'hFFFF_FFFF : 32'h0;
        o = 0;
        for (int i = 0; i < n; i++) begin
            w = model_mem[(b + i) % 16];
            case (md)
                0: begin s = {1'b0, r} + {1'b0, w}; r = s[31:0]; if (s[32]) o = 1; end
                1: if (w > r) r = w;
                2: if (w < r) r = w;
                default: r = r ^ w;
            endcase
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; m_done = 0; m_val = '0; m_regno = '0; m_ovf = 0; m_cnt = 0;
            end else begin
                m_done = 0;
                if (m_busy) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_busy = 0; m_done = 1; m_val = m_res; m_regno = 5'd11; m_ovf = m_res_ovf;
                        model_mem[m_dst] = m_res;
                    end
                end else begin
                    if (load_en) model_mem[load_addr] = load_data;
                    if (startin) begin
                        reduce(int'(mode), int'(base), int'(len), m_res, m_res_ovf);
                        m_dst  = int'(dst);
                        m_cnt  = ((len > 16) ? 16 : int'(len)) + 1;
                        m_busy = 1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && checking) begin
                chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
                chk("cyc_done", {31'b0, done}, {31'b0, m_done});
                chk("cyc_val", val, m_val);
                chk("cyc_regno", {27'b0, regNo}, {27'b0, m_regno});
                chk("cyc_ovf", {31'b0, ovf}, {31'b0, m_ovf});
            end
        end
    end

    task automatic load(input int a, input logic [31:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = 4'(a); load_data = d;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic run(input logic [1:0] md, input int b, input int l, input int d,
                       input bit perturb, output int lat);
        @(negedge clk);
        mode = md; base = 4'(b); len = 5'(l); dst = 4'(d); startin = 1'b1;
        @(posedge clk);
        #1;
        startin = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (perturb && lat == 2) begin
                startin = 1'b1; mode = 2'b11; base = 4'd9; len = 5'd1; dst = 4'd4;
                load_en = 1'b1; load_addr = 4'd3; load_data = 32'd1000;
            end else if (perturb && lat == 3) begin
                startin = 1'b0; load_en = 1'b0;
            end
        end
        if (!done) chk("done_timeout", 32'(lat), 32'(l + 1));
    endtask

    int lat;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_val", val, 32'd0);
        chk("rst_regno", {27'b0, regNo}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        checking = 1;

        for (int i = 0; i < 10; i++) load(i, 32'(i + 1));
        run(2'b00, 0, 10, 10, 0, lat);
        chk("sum10_lat", 32'(lat), 32'd11);
        chk("sum10_val", val, 32'd55);
        chk("sum10_regno", {27'b0, regNo}, 32'd11);
        chk("sum10_ovf", {31'b0, ovf}, 32'd0);
        chk("sum10_wb", dut.mem[10], 32'd55);

        load(14, 32'd5); load(15, 32'd7); load(0, 32'd9); load(1, 32'd11);
        run(2'b01, 14, 4, 5, 0, lat);
        chk("wrap_max_val", val, 32'd11);
        chk("wrap_max_lat", 32'(lat), 32'd5);
        run(2'b10, 14, 4, 6, 0, lat);
        chk("wrap_min_val", val, 32'd5);

        load(0, 32'hFFFF_FFFF); load(1, 32'hFFFF_FFFF);
        run(2'b00, 0, 2, 3, 0, lat);
        chk("ovf_sum_val", val, 32'hFFFF_FFFE);
        chk("ovf_sum_flag", {31'b0, ovf}, 32'd1);
        run(2'b11, 0, 2, 4, 0, lat);
        chk("ovf_xor_val", val, 32'd0);
        chk("ovf_xor_flag", {31'b0, ovf}, 32'd0);

        run(2'b10, 7, 0, 12, 0, lat);
        chk("len0_lat", 32'(lat), 32'd1);
        chk("len0_val", val, 32'hFFFF_FFFF);
        chk("len0_wb", dut.mem[12], 32'hFFFF_FFFF);

        for (int i = 0; i < 16; i++) load(i, 32'(i + 1));
        run(2'b00, 3, 31, 0, 0, lat);
        chk("clamp_lat", 32'(lat), 32'd17);
        chk("clamp_val", val, 32'd136);

        // mem[2..6] = 3..7 after the clamp run wrote mem[0]
        run(2'b00, 2, 5, 15, 1, lat);
        chk("perturb_lat", 32'(lat), 32'd6);
        chk("perturb_val", val, 32'd25);
        chk("perturb_mem3", dut.mem[3], 32'd4);
        repeat (3) @(posedge clk);
        #1;
        chk("perturb_norestart", {31'b0, busy}, 32'd0);

        @(negedge clk);
        mode = 2'b00; base = 4'd0; len = 5'd8; dst = 4'd9; startin = 1'b1;
        @(posedge clk);
        #1;
        startin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_midbusy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_val", val, 32'd0);
        chk("abort_regno", {27'b0, regNo}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_wb", dut.mem[9], 32'd10);
        run(2'b00, 0, 4, 9, 0, lat);
        chk("fresh_lat", 32'(lat), 32'd5);
        chk("fresh_val", val, 32'd145);
        chk("fresh_wb", dut.mem[9], 32'd145);

        // back-to-back: start presented in the cycle done is high
        @(negedge clk);
        mode = 2'b01; base = 4'd10; len = 5'd3; dst = 4'd14; startin = 1'b1;
        @(posedge clk);
        #1;
        startin = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("b2b_first_done", {31'b0, done}, 32'd1);
        mode = 2'b10; base = 4'd4; len = 5'd2; dst = 4'd13; startin = 1'b1;
        @(posedge clk);
        #1;
        startin = 1'b0;
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_val", val, 32'd5);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
